// File: rtl/phy_reg_free_list_if.sv
// Rename-stage free-list port bundle: allocation, release, commit and flush signals.
// The core side drives the master modport; the free list implements the slave modport.
interface phy_reg_free_list_if #(
    parameter int unsigned POP_WIDTH  = 2,
    parameter int unsigned PUSH_WIDTH = 2,
    parameter int unsigned REG_BITS   = 7,
    parameter int unsigned PTR_BITS   = 6
);
    logic                                 ready;
    logic                                 allocatable;
    logic [POP_WIDTH-1:0]                 popReq;
    logic [POP_WIDTH-1:0][REG_BITS-1:0]   popPhyReg;
    logic [PUSH_WIDTH-1:0]                pushReq;
    logic [PUSH_WIDTH-1:0][REG_BITS-1:0]  pushPhyReg;
    logic [PUSH_WIDTH-1:0]                commitAlloc;
    logic                                 flush;
    logic [PTR_BITS:0]                    count;
    logic                                 errOverflow;

    modport master (
        output popReq, pushReq, pushPhyReg, commitAlloc, flush,
        input  ready, allocatable, popPhyReg, count, errOverflow
    );

    modport slave (
        input  popReq, pushReq, pushPhyReg, commitAlloc, flush,
        output ready, allocatable, popPhyReg, count, errOverflow
    );
endinterface

// File: rtl/phy_reg_free_list.sv
// Circular free list of physical register numbers with a committed-head checkpoint,
// so a flush returns every speculative allocation in a single cycle.
module phy_reg_free_list #(
    parameter int unsigned ENTRY_NUM  = 64,
    parameter int unsigned POP_WIDTH  = 2,
    parameter int unsigned PUSH_WIDTH = 2,
    parameter int unsigned REG_BITS   = 7,
    parameter int unsigned PTR_BITS   = $clog2(ENTRY_NUM)
) (
    input logic                clk,
    input logic                rst,
    phy_reg_free_list_if.slave bus
);
    localparam int unsigned CNT_W = PTR_BITS + 2;

    typedef enum logic {StInit, StRun} state_e;

    state_e                state_q;
    logic [PTR_BITS-1:0]   head_q, tail_q, commit_head_q, init_idx_q;
    logic [PTR_BITS:0]     count_q, spec_q;
    logic                  ready_q, err_q;
    logic [REG_BITS-1:0]   mem_q [ENTRY_NUM];

    logic [CNT_W-1:0]      np, npush, ncommit, base, count_d, spec_d;
    logic                  run, pop_ok, pop_err, push_ok, push_err;
    logic [PTR_BITS-1:0]   head_d, tail_d, commit_head_d, push_off;
    logic [PUSH_WIDTH-1:0] wr_en;
    logic [PTR_BITS-1:0]   wr_addr [PUSH_WIDTH];

    always_comb begin
        np      = '0;
        npush   = '0;
        ncommit = '0;
        for (int i = 0; i < POP_WIDTH; i++) np = np + CNT_W'(bus.popReq[i]);
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            npush   = npush + CNT_W'(bus.pushReq[i]);
            ncommit = ncommit + CNT_W'(bus.commitAlloc[i]);
        end

        run     = (state_q == StRun);
        pop_ok  = run && !bus.flush && (np <= CNT_W'(count_q));
        pop_err = run && !bus.flush && (np > CNT_W'(count_q));

        // On flush, every uncommitted allocation (spec_q) comes back to the free pool.
        base = bus.flush ? CNT_W'(count_q) + CNT_W'(spec_q) - ncommit
                         : CNT_W'(count_q) - (pop_ok ? np : '0);
        push_ok  = run && ((base + npush) <= CNT_W'(ENTRY_NUM));
        push_err = run && (npush != '0) && !push_ok;
        count_d  = base + (push_ok ? npush : '0);

        commit_head_d = commit_head_q + PTR_BITS'(ncommit);
        head_d = bus.flush ? commit_head_d : head_q + (pop_ok ? PTR_BITS'(np) : '0);
        tail_d = tail_q + (push_ok ? PTR_BITS'(npush) : '0);
        spec_d = bus.flush ? '0 : CNT_W'(spec_q) + (pop_ok ? np : '0) - ncommit;

        push_off = '0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            wr_en[i]   = push_ok && bus.pushReq[i];
            wr_addr[i] = tail_q + push_off;
            push_off   = push_off + PTR_BITS'(bus.pushReq[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < POP_WIDTH; i++) begin
            bus.popPhyReg[i] = mem_q[head_q + PTR_BITS'(i)];
        end
    end

    assign bus.ready       = ready_q;
    assign bus.allocatable = ready_q && (count_q >= (PTR_BITS + 1)'(POP_WIDTH));
    assign bus.count       = count_q;
    assign bus.errOverflow = err_q;

    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem_q[init_idx_q] <= REG_BITS'(init_idx_q);
        end else begin
            for (int i = 0; i < PUSH_WIDTH; i++) begin
                if (wr_en[i]) mem_q[wr_addr[i]] <= bus.pushPhyReg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StInit;
            head_q        <= '0;
            tail_q        <= '0;
            commit_head_q <= '0;
            init_idx_q    <= '0;
            count_q       <= '0;
            spec_q        <= '0;
            ready_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == PTR_BITS'(ENTRY_NUM - 1)) begin
                        state_q <= StRun;
                        count_q <= (PTR_BITS + 1)'(ENTRY_NUM);
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    head_q        <= head_d;
                    tail_q        <= tail_d;
                    commit_head_q <= commit_head_d;
                    count_q       <= count_d[PTR_BITS:0];
                    spec_q        <= spec_d[PTR_BITS:0];
                    err_q         <= err_q | pop_err | push_err;
                end
                default: state_q <= StInit;
            endcase
        end
    end
endmodule

// File: tb/tb_phy_reg_free_list.sv
// Directed bench for phy_reg_free_list: the driver queues expected outputs, and a negedge
// monitor pops and compares them against the DUT.
module tb_phy_reg_free_list;
    localparam int unsigned N  = 64;
    localparam int unsigned PW = 2;
    localparam int unsigned UW = 2;
    localparam int unsigned RB = 7;
    localparam int unsigned PB = 6;

    localparam int IdReady = 0;
    localparam int IdAlloc = 1;
    localparam int IdCount = 2;
    localparam int IdPop0  = 3;
    localparam int IdPop1  = 4;
    localparam int IdErr   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    phy_reg_free_list_if #(.POP_WIDTH(PW), .PUSH_WIDTH(UW), .REG_BITS(RB), .PTR_BITS(PB)) bus();

    phy_reg_free_list #(
        .ENTRY_NUM (N),
        .POP_WIDTH (PW),
        .PUSH_WIDTH(UW),
        .REG_BITS  (RB),
        .PTR_BITS  (PB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int id;
        int val;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    function automatic string fname(int id);
        case (id)
            IdReady: return "ready";
            IdAlloc: return "allocatable";
            IdCount: return "count";
            IdPop0:  return "popPhyReg0";
            IdPop1:  return "popPhyReg1";
            default: return "errOverflow";
        endcase
    endfunction

    function automatic logic [31:0] field(int id);
        case (id)
            IdReady: return 32'(bus.ready);
            IdAlloc: return 32'(bus.allocatable);
            IdCount: return 32'(bus.count);
            IdPop0:  return 32'(bus.popPhyReg[0]);
            IdPop1:  return 32'(bus.popPhyReg[1]);
            default: return 32'(bus.errOverflow);
        endcase
    endfunction

    task automatic expect_eq(input int id, input int val);
        exp_t e;
        e.id  = id;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic expect_state(input int cnt, input int alloc, input int err);
        expect_eq(IdCount, cnt);
        expect_eq(IdAlloc, alloc);
        expect_eq(IdErr, err);
    endtask

    task automatic expect_pop(input int a, input int b);
        expect_eq(IdPop0, a);
        expect_eq(IdPop1, b);
    endtask

    task automatic idle();
        bus.popReq      = '0;
        bus.pushReq     = '0;
        bus.pushPhyReg  = '0;
        bus.commitAlloc = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic cyc(input logic [1:0] pr, input logic [1:0] pu, input logic [6:0] v0,
                       input logic [6:0] v1, input logic [1:0] ca, input logic fl);
        bus.popReq        = pr;
        bus.pushReq       = pu;
        bus.pushPhyReg[0] = v0;
        bus.pushPhyReg[1] = v1;
        bus.commitAlloc   = ca;
        bus.flush         = fl;
        @(posedge clk);
        #1;
        idle();
    endtask

    // Called just after rst is released; the 64th edge completes initialisation.
    task automatic do_init();
        for (int i = 0; i < N - 1; i++) begin
            @(posedge clk);
            #1;
            expect_eq(IdReady, 0);
        end
        @(posedge clk);
        #1;
        expect_eq(IdReady, 1);
        expect_state(64, 1, 0);
        expect_pop(0, 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e   = sb.pop_front();
                act = field(e.id);
                total++;
                if (act !== 32'(e.val)) begin
                    $display("FAIL %s: got %0d expected %0d", fname(e.id), act, e.val);
                end else begin
                    passed++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq(IdReady, 0);
        expect_state(0, 0, 0);
        rst = 1'b1;
        do_init();

        for (int k = 0; k < 3; k++) begin
            cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
            expect_eq(IdCount, 62 - 2 * k);
            expect_pop(2 * k + 2, 2 * k + 3);
        end

        // Flush with two same-cycle commits; the requested pops must be ignored.
        cyc(2'b11, 2'b00, 0, 0, 2'b11, 1'b1);
        expect_state(62, 1, 0);
        expect_pop(2, 3);

        cyc(2'b00, 2'b11, 0, 1, 2'b00, 1'b0);
        expect_state(64, 1, 0);
        expect_pop(2, 3);

        // Pop and push together at full: count holds while both pointers advance to 62.
        for (int k = 0; k < 30; k++) begin
            cyc(2'b11, 2'b11, 7'(2 + 2 * k), 7'(3 + 2 * k), 2'b00, 1'b0);
            expect_eq(IdCount, 64);
            expect_pop(4 + 2 * k, 5 + 2 * k);
        end
        cyc(2'b11, 2'b11, 40, 41, 2'b00, 1'b0);
        expect_state(64, 1, 0);
        expect_pop(0, 1);

        for (int k = 1; k <= 31; k++) begin
            cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
            expect_eq(IdCount, 64 - 2 * k);
            if (k < 31) expect_pop(2 * k, 2 * k + 1);
            else expect_pop(40, 41);
        end

        cyc(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        expect_state(1, 0, 0);
        expect_pop(41, 0);
        cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        expect_state(1, 0, 1);
        expect_pop(41, 0);
        cyc(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        expect_state(0, 0, 1);

        cyc(2'b00, 2'b10, 0, 77, 2'b00, 1'b0);
        expect_state(1, 0, 1);
        expect_eq(IdPop0, 77);
        for (int k = 0; k < 4; k++) begin
            cyc(2'b00, 2'b11, 7'(20 + 2 * k), 7'(21 + 2 * k), 2'b00, 1'b0);
            expect_eq(IdCount, 3 + 2 * k);
        end
        cyc(2'b00, 2'b01, 28, 0, 2'b00, 1'b0);
        expect_state(10, 1, 1);
        expect_pop(77, 20);

        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_eq(IdReady, 0);
        expect_state(0, 0, 0);
        rst = 1'b1;
        do_init();

        cyc(2'b00, 2'b01, 50, 0, 2'b00, 1'b0);
        expect_state(64, 1, 1);
        expect_pop(0, 1);

        total++;
        if (bus.ready !== 1'b1) begin
            $display("FAIL ready: got %0d expected 1", bus.ready);
        end else begin
            passed++;
        end
        total++;
        if (bus.count !== 7'd64) begin
            $display("FAIL count: got %0d expected 64", bus.count);
        end else begin
            passed++;
        end
        total++;
        if (bus.errOverflow !== 1'b1) begin
            $display("FAIL errOverflow: got %0d expected 1", bus.errOverflow);
        end else begin
            passed++;
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/phy_reg_free_list.md
Name: phy_reg_free_list

Overview:
- Circular free list of physical register numbers, in the rename stage.
- Supplies new destination physical registers to the register map table write path.
- Reclaims previous-destination registers released at commit.
- Checkpoints the committed head pointer so a pipeline flush returns all speculatively allocated registers in one cycle.

Parameters:
ENTRY_NUM, 64, number of free-list entries (power of two); entries are initialised to 0..ENTRY_NUM-1
POP_WIDTH, 2, allocations per cycle (rename width)
PUSH_WIDTH, 2, releases per cycle (commit width)
REG_BITS, 7, physical register number width
PTR_BITS, $clog2(ENTRY_NUM), derived pointer width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (rst==0 resets)
ready  out  1  initialisation complete; all requests are ignored while 0
allocatable  out  1  free count >= POP_WIDTH and ready
popReq  in  POP_WIDTH  allocation requests, prefix-packed (popReq[i] implies popReq[j] for all j<i)
popPhyReg  out  POP_WIDTH x REG_BITS  allocated register numbers, combinational from mem[head+i]
pushReq  in  PUSH_WIDTH  release requests, arbitrary pattern
pushPhyReg  in  PUSH_WIDTH x REG_BITS  released register numbers
commitAlloc  in  PUSH_WIDTH  committing op had a destination, so one allocation becomes non-speculative
flush  in  1  discard all uncommitted allocations
count  out  PTR_BITS+1  current free entries
errOverflow  out  1  sticky; push attempted when full or pop attempted beyond count

Behaviour:
- Reset (rst==0 at posedge):
  - State <= INIT; head, tail, commitHead, initIdx <= 0.
  - count <= 0; ready <= 0; errOverflow <= 0.
  - popPhyReg is undefined until ready.
- INIT state:
  - One entry written per cycle: mem[initIdx] <= initIdx; initIdx++.
  - popReq, pushReq, commitAlloc and flush are ignored.
  - After the write of ENTRY_NUM-1: state <= RUN, count <= ENTRY_NUM, ready <= 1.
  - ready first rises exactly ENTRY_NUM cycles after the rst release edge.
  - Reasserting rst at any point restarts INIT from entry 0.
- RUN, per cycle (all updates at posedge):
  - np = popcount(popReq). Pops occur only when np <= count and flush==0. Then head <= head+np and popPhyReg[i] = mem[(head+i) mod ENTRY_NUM].
  - np > count (while not flushing): no pop occurs, head is unchanged, errOverflow <= 1.
  - Pushes:
    - Valid pushes are compacted in port order.
    - The k-th valid push writes mem[(tail+k) mod ENTRY_NUM]; tail <= tail+nPush.
    - A push that would make count exceed ENTRY_NUM is dropped entirely (all pushes that cycle), with errOverflow <= 1.
  - commitHead <= commitHead + popcount(commitAlloc).
  - Count update, normal cycle: count <= count - np_eff + nPush_eff.
- flush==1:
  - head <= commitHead + popcount(commitAlloc) from that same cycle.
  - Same-cycle pushes and commitAlloc still apply; same-cycle pops are ignored.
  - count <= (tail_next - head_next) mod 2^PTR_BITS. A result of 0 with the list holding entries is resolved as ENTRY_NUM: count is recomputed so that count = ENTRY_NUM - (committed-but-not-yet-released allocations). Implementation keeps a separate inflight counter (commitHead to head distance) to disambiguate.
- Pointer arithmetic:
  - Pointers are PTR_BITS wide and wrap modulo ENTRY_NUM.
  - count is PTR_BITS+1 wide and never exceeds ENTRY_NUM.
- Read/write ordering:
  - A push and a pop in the same cycle never alias the same entry unless count==0.
  - With count==0 no pop is permitted, so there is no bypass from push to pop; a pushed register becomes allocatable the next cycle.
- allocatable = ready && count >= POP_WIDTH, combinational from registers.
- errOverflow stays set until reset.

Test Plan:
- Release rst after 3 low cycles -> ready=0 for 64 cycles, then ready=1, count=64, allocatable=1, popPhyReg={0,1}.
- popReq=11 for 3 cycles -> pops {0,1},{2,3},{4,5}; count=58; head=6.
- Allocate 6 with commitAlloc on 2 of them, then flush -> head=2, count=62, next popPhyReg={2,3}.
- Drain to count=1, then popReq=11 -> no pop, head unchanged, errOverflow=1. Alternatively popReq=01 -> pops one register, count=0, allocatable=0.
- count=64 with pushReq=01 -> push dropped, errOverflow=1. Pop 2, then push {40,41} in the same cycle as popReq=11 -> count unchanged, tail advances by 2, wrap verified at index 63->0.
- rst low mid-RUN with count=10 -> next cycle ready=0 and INIT restarts; after 64 cycles count=64 and popPhyReg={0,1}.
